// File: rtl/text_pkg.sv
// Shared definitions for the text-mode screen writer and the display read path.
package text_pkg;
  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [7:0] DEF_ATTR = 8'h70;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [2:0] {IDLE, WR_CHR, WR_ATTR, CLR_ALL, CLR_LINE} state_t;

  typedef struct packed {
    logic        en;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  // sel=1 addresses the character byte, sel=0 the attribute byte of a cell
  function automatic logic [15:0] pack_addr(input logic [4:0] row, input logic [6:0] col,
                                            input logic sel);
    return {3'b000, row, col, sel};
  endfunction
endpackage

// File: rtl/cell_clear_seq.sv
// Emits space/attribute byte pairs over a band of rows, one byte per cycle, then pulses done.
module cell_clear_seq
  import text_pkg::*;
#(
  parameter int         COLS     = COLS_DEF,
  parameter int         ROWS     = ROWS_DEF,
  parameter logic [7:0] RST_ATTR = 8'h70
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] start_row,
  input  logic [5:0] row_cnt,
  input  logic [7:0] attr,
  output wr_t        wr,
  output logic       done
);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);

  logic       running, sel;
  logic [4:0] row, end_row;
  logic [6:0] col;
  logic [7:0] fill_attr;
  logic       last;

  assign last = !sel && (col == COL_LAST) && (row == end_row);

  // Reset leaves the sequencer already running a full-screen clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      running   <= 1'b1;
      sel       <= 1'b1;
      row       <= '0;
      col       <= '0;
      end_row   <= 5'(ROWS - 1);
      fill_attr <= RST_ATTR;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        running   <= 1'b1;
        sel       <= 1'b1;
        row       <= start_row;
        col       <= '0;
        end_row   <= start_row + 5'(row_cnt - 6'd1);
        fill_attr <= attr;
      end else if (running) begin
        if (last) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
        sel <= !sel;
        if (!sel) begin
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 5'd1;
          end else begin
            col <= col + 7'd1;
          end
        end
      end
    end
  end

  assign wr = '{en: running, addr: pack_addr(row, col, sel), data: (sel ? SPACE : fill_attr)};
endmodule

// File: rtl/text_writer.sv
// Host byte stream to text screen RAM writer: cursor, control codes, line and screen clears.
module text_writer
  import text_pkg::*;
#(
  parameter int         COLS     = COLS_DEF,
  parameter int         ROWS     = ROWS_DEF,
  parameter logic [7:0] DEF_ATTR = 8'h70
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        attr_we,
  input  logic [7:0]  attr_in,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        busy
);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  state_t     state;
  logic [7:0] attr, work_attr;
  logic [4:0] row_nxt;
  logic       accept, is_print, wrap;
  logic       seq_start, seq_done;
  logic [4:0] seq_row;
  logic [5:0] seq_cnt;
  wr_t        seq_wr;

  assign accept   = in_valid && in_ready;
  assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign row_nxt  = (cur_row == ROW_LAST) ? 5'd0 : cur_row + 5'd1;
  assign wrap     = (state == WR_ATTR) && (cur_col == COL_LAST);
  assign busy     = !in_ready;

  // Clears are launched on the same edge the FSM enters its clear state.
  always_comb begin
    seq_start = 1'b0;
    seq_row   = row_nxt;
    seq_cnt   = 6'd1;
    if (accept && in_data == CH_FF) begin
      seq_start = 1'b1;
      seq_row   = '0;
      seq_cnt   = 6'(ROWS);
    end else if ((accept && in_data == CH_LF) || wrap) begin
      seq_start = 1'b1;
    end
  end

  cell_clear_seq #(.COLS(COLS), .ROWS(ROWS), .RST_ATTR(DEF_ATTR)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .start    (seq_start),
    .start_row(seq_row),
    .row_cnt  (seq_cnt),
    .attr     (attr),
    .wr       (seq_wr),
    .done     (seq_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLR_ALL;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cur_col   <= '0;
      cur_row   <= '0;
      attr      <= DEF_ATTR;
      work_attr <= DEF_ATTR;
    end else begin
      if (attr_we) attr <= attr_in;
      wr_en <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (is_print) begin
            wr_en     <= 1'b1;
            wr_addr   <= pack_addr(cur_row, cur_col, 1'b1);
            wr_data   <= in_data;
            work_attr <= attr;
            state     <= WR_CHR;
            in_ready  <= 1'b0;
          end else begin
            case (in_data)
              CH_CR: cur_col <= '0;
              CH_LF: begin
                cur_row  <= row_nxt;
                state    <= CLR_LINE;
                in_ready <= 1'b0;
              end
              CH_BS: if (cur_col != 7'd0) cur_col <= cur_col - 7'd1;
              CH_FF: begin
                cur_row  <= '0;
                cur_col  <= '0;
                state    <= CLR_ALL;
                in_ready <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        WR_CHR: begin
          wr_en   <= 1'b1;
          wr_addr <= pack_addr(cur_row, cur_col, 1'b0);
          wr_data <= work_attr;
          state   <= WR_ATTR;
        end
        WR_ATTR: begin
          if (cur_col == COL_LAST) begin
            cur_col <= '0;
            cur_row <= row_nxt;
            state   <= CLR_LINE;
          end else begin
            cur_col  <= cur_col + 7'd1;
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        CLR_ALL, CLR_LINE: begin
          wr_en   <= seq_wr.en;
          wr_addr <= seq_wr.addr;
          wr_data <= seq_wr.data;
          if (seq_done) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: a queue-based screen-write model checked on every write cycle.
module tb_text_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, attr_we = 1'b0;
  logic [7:0]  in_data = '0, attr_in = '0;
  logic        in_ready, wr_en, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .DEF_ATTR(8'h70)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .attr_we(attr_we), .attr_in(attr_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  logic [23:0] exp_q[$];
  int log_a[$], log_d[$], log_c[$];
  int m_row, m_col;
  logic [7:0] m_attr;
  logic [23:0] e;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int paddr(input int r, input int c, input int s);
    return r * 256 + c * 2 + s;
  endfunction

  task automatic push_wr(input int a, input int d);
    exp_q.push_back({a[15:0], d[7:0]});
  endtask

  task automatic push_clear(input int r0, input int n, input logic [7:0] a);
    for (int r = r0; r < r0 + n; r++)
      for (int c = 0; c < COLS; c++) begin
        push_wr(paddr(r, c, 1), 'h20);
        push_wr(paddr(r, c, 0), int'(a));
      end
  endtask

  task automatic row_adv(input logic [7:0] a);
    m_row = (m_row + 1) % ROWS;
    push_clear(m_row, 1, a);
  endtask

  // Every write the DUT makes must be the next one the model expects.
  always @(negedge clk) begin
    if (wr_en) begin
      log_a.push_back(int'(wr_addr));
      log_d.push_back(int'(wr_data));
      log_c.push_back(cyc);
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(wr_addr), int'(e[23:8]));
        chk("wr_data", int'(wr_data), int'(e[7:0]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(output int rc);
    int k = 0;
    while (!in_ready && k < 20000) begin
      step();
      k++;
    end
    if (!in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 20000 cycles");
    end
    rc = cyc;
  endtask

  task automatic chk_log(input string nm, input int idx, input int a, input int d);
    if (idx >= 0 && idx < log_a.size()) begin
      chk({nm, "_addr"}, log_a[idx], a);
      chk({nm, "_data"}, log_d[idx], d);
    end else begin
      nchk++;
      nerr++;
      $display("FAIL %s: got no write #%0d expected addr 0x%0h", nm, idx, a);
    end
  endtask

  task automatic drive(input logic [7:0] b, input bit we, input logic [7:0] a, output int dcyc);
    logic [7:0] la;
    la = m_attr;
    if (we) m_attr = a;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(paddr(m_row, m_col, 1), int'(b));
      push_wr(paddr(m_row, m_col, 0), int'(la));
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        row_adv(m_attr);
      end
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) row_adv(la);
    else if (b == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (b == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      push_clear(0, ROWS, la);
    end
    in_valid = 1'b1; in_data = b; attr_we = we; attr_in = a;
    dcyc = cyc;
    step();
    in_valid = 1'b0; attr_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit we, input logic [7:0] a,
                      output int dcyc, output int rcyc);
    int dummy;
    wait_ready(dummy);
    drive(b, we, a, dcyc);
    wait_ready(rcyc);
    chk("cur_col", int'(cur_col), m_col);
    chk("cur_row", int'(cur_row), m_row);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    int base, d, r, k;
    m_row = 0; m_col = 0; m_attr = 8'h70;

    repeat (3) step();
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_cur_col", int'(cur_col), 0);
    chk("rst_cur_row", int'(cur_row), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 1);

    push_clear(0, ROWS, 8'h70);
    base = log_a.size();
    rst = 1'b0;
    wait_ready(r);
    chk("boot_clear_count", log_a.size() - base, 4800);
    chk_log("boot_first", base, 'h0001, 'h20);
    chk_log("boot_second", base + 1, 'h0000, 'h70);
    chk_log("boot_last", log_a.size() - 1, 'h1D9E, 'h70);
    chk("boot_ready_rise", r - log_c[log_c.size() - 1], 1);
    chk("boot_pending", exp_q.size(), 0);

    base = log_a.size();
    send(8'h41, 1'b0, 8'h00, d, r);
    chk_log("A_chr", base, 'h0001, 'h41);
    chk_log("A_attr", base + 1, 'h0000, 'h70);
    chk("A_col", int'(cur_col), 1);
    chk("A_ready_latency", r - d, 3);

    for (int i = 0; i < 4; i++) send(8'(97 + i), 1'b0, 8'h00, d, r);
    base = log_a.size();
    send(8'h0A, 1'b0, 8'h00, d, r);
    chk("LF_row", int'(cur_row), 1);
    chk("LF_col", int'(cur_col), 5);
    chk("LF_count", log_a.size() - base, 160);
    chk_log("LF_first", base, 'h0101, 'h20);
    chk_log("LF_last_chr", base + 158, 'h019F, 'h20);
    chk_log("LF_last_attr", base + 159, 'h019E, 'h70);

    for (int i = 0; i < 28; i++) send(8'h0A, 1'b0, 8'h00, d, r);
    send(8'h0D, 1'b0, 8'h00, d, r);
    for (int i = 0; i < 79; i++) send(8'(97 + i % 26), 1'b0, 8'h00, d, r);
    chk("corner_row", int'(cur_row), 29);
    chk("corner_col", int'(cur_col), 79);

    base = log_a.size();
    send(8'h5A, 1'b0, 8'h00, d, r);
    chk_log("Z_chr", base, 'h1D9F, 'h5A);
    chk_log("Z_attr", base + 1, 'h1D9E, 'h70);
    chk_log("Z_clr_first", base + 2, 'h0001, 'h20);
    chk_log("Z_clr_last", base + 161, 'h009E, 'h70);
    chk("Z_count", log_a.size() - base, 162);
    chk("Z_row", int'(cur_row), 0);
    chk("Z_col", int'(cur_col), 0);

    base = log_a.size();
    send(8'h42, 1'b1, 8'h1E, d, r);
    chk_log("B_chr", base, 'h0001, 'h42);
    chk_log("B_attr", base + 1, 'h0000, 'h70);
    base = log_a.size();
    send(8'h43, 1'b0, 8'h00, d, r);
    chk_log("C_chr", base, 'h0003, 'h43);
    chk_log("C_attr", base + 1, 'h0002, 'h1E);

    send(8'h08, 1'b0, 8'h00, d, r);
    chk("BS_col", int'(cur_col), 1);
    send(8'h0D, 1'b0, 8'h00, d, r);
    base = log_a.size();
    send(8'h08, 1'b0, 8'h00, d, r);
    chk("BS0_col", int'(cur_col), 0);
    send(8'h07, 1'b0, 8'h00, d, r);
    chk("BEL_no_write", log_a.size() - base, 0);

    wait_ready(r);
    drive(8'h0C, 1'b0, 8'h00, d);
    base = log_a.size();
    k = 0;
    while (log_a.size() - base < 1000 && k < 3000) begin
      step();
      k++;
    end
    chk("FF_reach_1000", log_a.size() - base, 1000);
    rst = 1'b1;
    exp_q.delete();
    step();
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    m_attr = 8'h70; m_row = 0; m_col = 0;
    push_clear(0, ROWS, 8'h70);
    base = log_a.size();
    rst = 1'b0;
    wait_ready(r);
    chk("restart_count", log_a.size() - base, 4800);
    chk_log("restart_first", base, 'h0001, 'h20);
    chk_log("restart_attr", base + 1, 'h0000, 'h70);
    chk("restart_col", int'(cur_col), 0);
    chk("restart_row", int'(cur_row), 0);
    chk("restart_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Host-side writer for the text-mode screen memory that the character/colour display path reads.
- Accepts a byte stream (ASCII plus a few control codes) and writes character and attribute bytes into screen RAM at a cursor position.
- Maintains the cursor. Performs line clears and full-screen clears.
- Sits between the host/UART command path and the screen RAM write port.

Parameters:
COLS, 80, text columns per row (at most 128)
ROWS, 30, text rows (at most 32)
DEF_ATTR, 8'h70, attribute loaded at reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  host byte valid
in_data  in  8  host byte
in_ready  out  1  writer can accept a byte this cycle
attr_we  in  1  load attr_in into the current-attribute register
attr_in  in  8  attribute byte: [7] fg bright, [6:4] fg RGB, [3] bg bright, [2:0] bg RGB
wr_en  out  1  screen RAM byte write strobe
wr_addr  out  16  screen RAM byte address
wr_data  out  8  screen RAM write data
cur_col  out  7  cursor column
cur_row  out  5  cursor row
busy  out  1  a write or clear sequence is in progress

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Address map (fixed):
  - wr_addr[15:13]=0, [12:8]=row, [7:1]=col.
  - [0]=1 selects the character byte; [0]=0 selects the attribute byte.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0.
  - cur_col=0, cur_row=0, attr=DEF_ATTR.
  - in_ready=0, state=CLR_ALL (full clear runs after reset).
- States:
  - IDLE: in_ready=1, busy=0, wr_en=0.
  - WR_CHR, WR_ATTR, CLR_ALL, CLR_LINE.
- Handshake: a byte is accepted when in_valid & in_ready. in_ready=1 only in IDLE.
- Attribute latching: the attribute is latched into a working register on acceptance and at the start of any clear sequence.
  - attr_we updates the current attribute in any state, including when it coincides with an acceptance.
  - It never alters an in-flight sequence; the new value takes effect from the next latch.
- Printable bytes 0x20-0x7E:
  - Acceptance cycle N.
  - N+1 (WR_CHR): wr_en=1, addr={row,col,1}, data=byte.
  - N+2 (WR_ATTR): wr_en=1, addr={row,col,0}, data=latched attribute.
  - Cursor then advances, giving 3 cycles per character.
- Control codes, all accepted in one cycle:
  - 0x0D (CR): col=0.
  - 0x0A (LF): row advance; col unchanged.
  - 0x08 (BS): col=col-1 if col>0, else no-op; nothing is erased.
  - 0x0C (FF): cursor to (0,0), then CLR_ALL.
  - All other bytes are consumed and ignored.
- Cursor advance: col+1. If col==COLS-1, col=0 followed by a row advance.
- Row advance:
  - row=row+1, or row=0 if row==ROWS-1 (no scrolling; wrap).
  - Then CLR_LINE on the new row.
- CLR_LINE: for col 0..COLS-1, writes char 0x20 then the attribute, one byte per cycle. Length is 2*COLS cycles; returns to IDLE.
- CLR_ALL: same sequence for every row 0..ROWS-1, row-major. Length is 2*COLS*ROWS cycles (4800 by default). Cursor stays at (0,0).
- wr_en is asserted only in WR_CHR, WR_ATTR and the clear states.
- Every wr_addr is within rows<ROWS and cols<COLS.
- rst mid-sequence: wr_en=0 in the following cycle, the sequence is abandoned, and the full clear restarts from (0,0).
- cur_col/cur_row update in the cycle the sequence completes. LF and CR update in the cycle after acceptance.

Decomposition:
- Shared package text_pkg holds:
  - COLS/ROWS defaults, control code constants, SPACE=8'h20, DEF_ATTR.
  - The state enum.
  - A pack_addr(row,col,sel) function. The display path uses the same function for its read address.
- One sub-module, cell_clear_seq: given start row, row count and attribute, it generates the char/attr write stream and a done pulse. It is reused by CLR_LINE and CLR_ALL.

Test Plan:
- Release rst: exactly 4800 writes; first is 0x0001=0x20, then 0x0000=0x70; last is 0x1D9E=0x70. in_ready rises the cycle after.
- Send 0x41 at (0,0) with attr 0x70: write 0x0001=0x41, then 0x0000=0x70; cur_col=1; in_ready high again 3 cycles after acceptance.
- Cursor (0,5), send 0x0A: cur_row=1, cur_col=5. 160 writes follow, covering 0x0101..0x019F (char 0x20, attr bytes 0x70).
- Cursor (29,79), send 'Z': write 0x1D9F=0x5A, 0x1D9E=attr. Cursor goes to (0,0) and row 0 is cleared (0x0001..0x009F).
- attr_we with 0x1E on the same cycle 'B' is accepted: 'B' attribute is 0x70; the next 'C' attribute is 0x1E. BS at col 0 is a no-op; 0x07 is consumed with no write.
- Send 0x0C, then assert rst at clear cycle 1000: wr_en=0 next cycle, then a full 4800-write clear restarts at 0x0001, with attr back to 0x70.
